// File: rtl/bus_mem_interface_pkg.sv
// Bus message codes shared with the coherence logic, plus helpers that
// classify which bus messages the memory side has to service.
package bus_mem_interface_pkg;

  localparam int MSG_CODE_BITS = 4;
  typedef logic [MSG_CODE_BITS-1:0] msg_code_t;

  localparam msg_code_t NO_REQ    = 4'h0;
  localparam msg_code_t R_REQ     = 4'h1;
  localparam msg_code_t RFO_BCAST = 4'h2;
  localparam msg_code_t WB_REQ    = 4'h3;
  localparam msg_code_t FLUSH     = 4'h4;
  localparam msg_code_t MEM_RESP  = 4'h5;
  localparam msg_code_t WS_BCAST  = 4'h6;
  localparam msg_code_t HOLD_BUS  = 4'h7;
  localparam msg_code_t REQ_FLUSH = 4'h8;

  function automatic logic is_mem_req(msg_code_t m);
    return (m == R_REQ) || (m == RFO_BCAST) || (m == WB_REQ) || (m == FLUSH);
  endfunction

  // Write-backs and flushes carry dirty data to the backing store.
  function automatic logic is_mem_write(msg_code_t m);
    return (m == WB_REQ) || (m == FLUSH);
  endfunction

endpackage

// File: rtl/bus_mem_interface.sv
// Memory-side bus agent: captures a granted bus request, issues it to the
// backing store with valid/ready, waits for the response and answers MEM_RESP.
module bus_mem_interface
  import bus_mem_interface_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int MSG_BITS     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     bus_msg,
  input  logic [ADDRESS_BITS-1:0] bus_address,
  input  logic [DATA_WIDTH-1:0]   bus_data,
  input  logic                    req_ready,
  output logic [MSG_BITS-1:0]     mem2controller_msg,
  output logic [DATA_WIDTH-1:0]   mem_bus_data,
  output logic [ADDRESS_BITS-1:0] mem_bus_address,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDRESS_BITS-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  localparam logic [MSG_BITS-1:0] M_NO_REQ   = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] M_MEM_RESP = MSG_BITS'(MEM_RESP);

  state_t                  state;
  logic [MSG_BITS-1:0]     hold_msg;
  logic [ADDRESS_BITS-1:0] hold_addr;
  logic [DATA_WIDTH-1:0]   hold_data;

  // The holding registers are the request fields, so they stay stable
  // for as long as the backing store stalls.
  assign mem_req_addr = hold_addr;
  assign mem_req_data = hold_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      hold_msg           <= '0;
      hold_addr          <= '0;
      hold_data          <= '0;
      mem_req_valid      <= 1'b0;
      mem_req_we         <= 1'b0;
      mem2controller_msg <= M_NO_REQ;
      mem_bus_data       <= '0;
      mem_bus_address    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready && is_mem_req(MSG_CODE_BITS'(bus_msg))) begin
            hold_msg      <= bus_msg;
            hold_addr     <= bus_address;
            hold_data     <= bus_data;
            mem_req_valid <= 1'b1;
            mem_req_we    <= is_mem_write(MSG_CODE_BITS'(bus_msg));
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_valid && mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            state         <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            mem_bus_data       <= is_mem_write(MSG_CODE_BITS'(hold_msg)) ? hold_data
                                                                         : mem_resp_data;
            mem_bus_address    <= hold_addr;
            mem2controller_msg <= M_MEM_RESP;
            state              <= RESPOND;
          end
        end
        RESPOND: begin
          if (bus_msg == M_NO_REQ) begin
            mem2controller_msg <= M_NO_REQ;
            state              <= IDLE;
          end
        end
        default: begin
          mem_req_valid      <= 1'b0;
          mem_req_we         <= 1'b0;
          mem2controller_msg <= M_NO_REQ;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_interface.sv
// Directed bench for bus_mem_interface: a table of full transactions plus
// hand-written sequences for ignored input, stray responses and mid-flight reset.
module tb_bus_mem_interface;
  import bus_mem_interface_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  bus_msg;
  logic [31:0] bus_address;
  logic [31:0] bus_data;
  logic        req_ready;
  logic [3:0]  mem2controller_msg;
  logic [31:0] mem_bus_data;
  logic [31:0] mem_bus_address;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_vec = 0;
  int n_err = 0;

  bus_mem_interface #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .MSG_BITS(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .bus_msg            (bus_msg),
    .bus_address        (bus_address),
    .bus_data           (bus_data),
    .req_ready          (req_ready),
    .mem2controller_msg (mem2controller_msg),
    .mem_bus_data       (mem_bus_data),
    .mem_bus_address    (mem_bus_address),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_we         (mem_req_we),
    .mem_req_addr       (mem_req_addr),
    .mem_req_data       (mem_req_data),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  msg;
    logic [31:0] addr;
    logic [31:0] data;
    int          rdy_wait;
    int          resp_wait;
    logic [31:0] resp;
    logic        we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(string name);
    chk({name, " valid"}, 32'(mem_req_valid), 32'(0));
    chk({name, " msg"},   32'(mem2controller_msg), 32'(NO_REQ));
  endtask

  task automatic chk_request(string name, vec_t v);
    chk({name, " valid"}, 32'(mem_req_valid), 32'(1));
    chk({name, " we"},    32'(mem_req_we), 32'(v.we));
    chk({name, " addr"},  mem_req_addr, v.addr);
    chk({name, " data"},  mem_req_data, v.data);
    chk({name, " msg"},   32'(mem2controller_msg), 32'(NO_REQ));
  endtask

  // Full transaction: capture, optional backpressure, accept, wait, respond, release.
  task automatic run_txn(vec_t v, string name);
    bus_msg       = v.msg;
    bus_address   = v.addr;
    bus_data      = v.data;
    req_ready     = 1'b1;
    mem_req_ready = (v.rdy_wait == 0);
    tick();
    req_ready   = 1'b0;
    bus_msg     = WS_BCAST;
    bus_address = 32'h0;
    bus_data    = 32'h0;
    for (int i = 0; i < v.rdy_wait; i++) begin
      chk_request({name, " stall"}, v);
      tick();
    end
    mem_req_ready = 1'b1;
    chk_request({name, " req"}, v);
    tick();
    mem_req_ready = 1'b0;
    chk_idle_outputs({name, " accepted"});
    for (int i = 0; i < v.resp_wait; i++) begin
      tick();
      chk_idle_outputs({name, " wait"});
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = v.resp;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    chk({name, " resp msg"},  32'(mem2controller_msg), 32'(MEM_RESP));
    chk({name, " resp data"}, mem_bus_data, v.exp_data);
    chk({name, " resp addr"}, mem_bus_address, v.addr);
    tick();
    chk({name, " resp held"}, 32'(mem2controller_msg), 32'(MEM_RESP));
    bus_msg = NO_REQ;
    tick();
    chk_idle_outputs({name, " release"});
  endtask

  task automatic chk_reset_outputs(string name);
    chk({name, " msg"},   32'(mem2controller_msg), 32'(NO_REQ));
    chk({name, " valid"}, 32'(mem_req_valid), 32'(0));
    chk({name, " we"},    32'(mem_req_we), 32'(0));
    chk({name, " addr"},  mem_req_addr, 32'h0);
    chk({name, " data"},  mem_req_data, 32'h0);
    chk({name, " bdata"}, mem_bus_data, 32'h0);
    chk({name, " baddr"}, mem_bus_address, 32'h0);
  endtask

  initial begin
    vecs[0] = '{R_REQ,     32'h0000_0100, 32'h0000_0000, 0, 1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{WB_REQ,    32'h0000_0040, 32'h1234_5678, 0, 0, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678};
    vecs[2] = '{RFO_BCAST, 32'h0000_2000, 32'hFFFF_0000, 5, 2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{FLUSH,     32'hFFFF_FFFC, 32'h0BAD_F00D, 2, 0, 32'h1111_1111, 1'b1, 32'h0BAD_F00D};
    vecs[4] = '{R_REQ,     32'h0000_0500, 32'h5555_AAAA, 0, 0, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F};

    reset          = 1'b1;
    bus_msg        = NO_REQ;
    bus_address    = 32'h0;
    bus_data       = 32'h0;
    req_ready      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Non-memory messages, ungranted requests and stray responses in IDLE.
    req_ready      = 1'b1;
    bus_msg        = WS_BCAST;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h4444_4444;
    tick();
    chk_idle_outputs("ign ws_bcast");
    bus_msg        = HOLD_BUS;
    mem_resp_valid = 1'b0;
    tick();
    chk_idle_outputs("ign hold_bus");
    req_ready   = 1'b0;
    bus_msg     = R_REQ;
    bus_address = 32'h0000_0900;
    tick();
    tick();
    chk_idle_outputs("ign no grant");
    bus_msg       = NO_REQ;
    mem_req_ready = 1'b0;
    tick();

    // Stray response while the request is still stalled in ISSUE.
    bus_msg     = R_REQ;
    bus_address = 32'h0000_0300;
    bus_data    = 32'h0;
    req_ready   = 1'b1;
    tick();
    req_ready      = 1'b0;
    bus_msg        = WS_BCAST;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h9999_9999;
    tick();
    mem_resp_valid = 1'b0;
    chk("stray issue valid", 32'(mem_req_valid), 32'(1));
    chk("stray issue msg", 32'(mem2controller_msg), 32'(NO_REQ));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    chk_idle_outputs("stray wait");
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_7777;
    tick();
    mem_resp_valid = 1'b0;
    chk("stray resp msg", 32'(mem2controller_msg), 32'(MEM_RESP));
    chk("stray resp data", mem_bus_data, 32'h7777_7777);
    chk("stray resp addr", mem_bus_address, 32'h0000_0300);
    bus_msg = NO_REQ;
    tick();
    chk_idle_outputs("stray release");

    // Reset in WAIT_RESP: outputs clear asynchronously, later response is dropped.
    bus_msg     = WB_REQ;
    bus_address = 32'h0000_0700;
    bus_data    = 32'h2222_2222;
    req_ready   = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    bus_msg   = WS_BCAST;
    tick();
    mem_req_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async reset");
    tick();
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h3333_3333;
    tick();
    mem_resp_valid = 1'b0;
    chk_idle_outputs("post reset stray");
    tick();
    chk_idle_outputs("post reset quiet");
    bus_msg = NO_REQ;

    // First request right after reset release is accepted immediately.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_txn(vecs[4], "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
